// File: rtl/song_transport_pkg.sv
// rtl/song_transport_pkg.sv - transport state encoding and tempo constant shared with song_player
package song_transport_pkg;

  // Transport states; the encoding is also decoded by song_player
  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2
  } transport_state_t;

  // Phase increment per BPM unit, rounded to nearest:
  // steps * subticks * 2^phase_bits / (60 * clk_freq)
  function automatic longint tempo_k(input longint clk_freq, input longint steps,
                                     input longint subticks, input longint phase_bits);
    longint num;
    longint den;
    num = (steps * subticks) << phase_bits;
    den = 60 * clk_freq;
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/song_transport_tick_nco.sv
// rtl/song_transport_tick_nco.sv - BPM-scaled phase accumulator producing a raw carry strobe
module song_transport_tick_nco #(
  parameter int                    PHASE_BITS = 32,
  parameter logic [PHASE_BITS-1:0] K          = '0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_bpm,
  input  logic       i_hold,
  input  logic       i_clear,
  output logic       o_tick_raw
);

  logic [PHASE_BITS-1:0] r_inc;
  logic [PHASE_BITS-1:0] r_acc;
  logic [PHASE_BITS-1:0] w_inc_next;
  logic [PHASE_BITS:0]   w_sum;

  assign w_inc_next = PHASE_BITS'(i_bpm) * K;
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc};
  // Carry is a pure function of the registers so the parent can gate it
  // with hold/clear without forming a combinational loop.
  assign o_tick_raw = w_sum[PHASE_BITS];

  // Increment follows bpm with one cycle of latency; clear beats hold
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_inc <= '0;
      r_acc <= '0;
    end else begin
      r_inc <= w_inc_next;
      if (i_clear) begin
        r_acc <= '0;
      end else if (!i_hold) begin
        r_acc <= w_sum[PHASE_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/song_transport.sv
// rtl/song_transport.sv - tempo/transport generator: play/pause/stop FSM, song position, end-of-song
module song_transport
  import song_transport_pkg::*;
#(
  parameter int  CLK_FREQ       = 16000000,
  parameter int  PHASE_BITS     = 32,
  parameter int  STEPS_PER_BEAT = 4,
  parameter int  SUBTICKS       = 8,
  parameter int  ROWS_PER_BAR   = 16,
  parameter int  BAR_BITS       = 6,
  localparam int SUB_W          = $clog2(SUBTICKS),
  localparam int ROW_W          = $clog2(ROWS_PER_BAR)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [7:0]          i_bpm,
  input  logic                i_cmd_play,
  input  logic                i_cmd_pause,
  input  logic                i_cmd_stop,
  input  logic                i_loop_en,
  input  logic [BAR_BITS-1:0] i_song_len_bars,
  output logic                o_tick,
  output logic                o_row_strobe,
  output logic [SUB_W-1:0]    o_subtick,
  output logic [ROW_W-1:0]    o_row,
  output logic [BAR_BITS-1:0] o_bar,
  output logic                o_playing,
  output logic                o_song_end
);

  localparam logic [PHASE_BITS-1:0] K =
    PHASE_BITS'(tempo_k(longint'(CLK_FREQ), longint'(STEPS_PER_BEAT),
                        longint'(SUBTICKS), longint'(PHASE_BITS)));
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUBTICKS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS_PER_BAR - 1);

  transport_state_t    r_state;
  transport_state_t    w_state_next;
  logic [SUB_W-1:0]    r_sub;
  logic [ROW_W-1:0]    r_row;
  logic [BAR_BITS-1:0] r_bar;
  logic                r_tick;
  logic                r_row_strobe;
  logic                r_song_end;

  logic                w_carry;
  logic                w_hold;
  logic                w_clear;
  logic                w_start;
  logic                w_adv;
  logic                w_wrap;
  logic                w_end_stop;
  logic                w_at_end;
  logic [BAR_BITS-1:0] w_last_bar;

  song_transport_tick_nco #(
    .PHASE_BITS (PHASE_BITS),
    .K          (K)
  ) u_nco (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_bpm      (i_bpm),
    .i_hold     (w_hold),
    .i_clear    (w_clear),
    .o_tick_raw (w_carry)
  );

  // A zero song length behaves as a one-bar song
  assign w_last_bar = (i_song_len_bars == '0) ? '0 : i_song_len_bars - 1'b1;
  // >= also catches a song shortened below the current bar mid-play
  assign w_at_end   = (r_sub == SUB_MAX) && (r_row == ROW_MAX) && (r_bar >= w_last_bar);

  // Next state and NCO control; stop beats play beats pause
  always_comb begin
    w_state_next = r_state;
    w_hold       = 1'b1;
    w_clear      = 1'b0;
    w_start      = 1'b0;
    w_adv        = 1'b0;
    w_wrap       = 1'b0;
    w_end_stop   = 1'b0;
    case (r_state)
      ST_STOPPED: begin
        w_clear = 1'b1;
        if (i_cmd_play && !i_cmd_stop) begin
          w_state_next = ST_PLAYING;
          w_start      = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (i_cmd_stop) begin
          w_state_next = ST_STOPPED;
          w_clear      = 1'b1;
        end else if (i_cmd_pause && !i_cmd_play) begin
          w_state_next = ST_PAUSED;
        end else begin
          w_hold = 1'b0;
        end
      end
      ST_PAUSED: begin
        if (i_cmd_stop) begin
          w_state_next = ST_STOPPED;
          w_clear      = 1'b1;
        end else if (i_cmd_play) begin
          // Accumulation restarts on the following cycle from the held phase
          w_state_next = ST_PLAYING;
        end
      end
      default: begin
        w_state_next = ST_STOPPED;
        w_clear      = 1'b1;
      end
    endcase
    w_adv      = w_carry && !w_hold;
    w_wrap     = w_adv && w_at_end && i_loop_en;
    w_end_stop = w_adv && w_at_end && !i_loop_en;
    if (w_end_stop) begin
      w_state_next = ST_STOPPED;
      w_clear      = 1'b1;
    end
  end

  // Transport state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_STOPPED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Position counters and one-cycle strobes, all registered
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sub        <= '0;
      r_row        <= '0;
      r_bar        <= '0;
      r_tick       <= 1'b0;
      r_row_strobe <= 1'b0;
      r_song_end   <= 1'b0;
    end else begin
      r_tick       <= 1'b0;
      r_row_strobe <= 1'b0;
      r_song_end   <= 1'b0;
      if (w_start) begin
        r_sub        <= '0;
        r_row        <= '0;
        r_bar        <= '0;
        r_tick       <= 1'b1;
        r_row_strobe <= 1'b1;
      end else if (w_end_stop) begin
        r_sub      <= '0;
        r_row      <= '0;
        r_bar      <= '0;
        r_song_end <= 1'b1;
      end else if (w_clear) begin
        r_sub <= '0;
        r_row <= '0;
        r_bar <= '0;
      end else if (w_wrap) begin
        r_sub        <= '0;
        r_row        <= '0;
        r_bar        <= '0;
        r_tick       <= 1'b1;
        r_row_strobe <= 1'b1;
        r_song_end   <= 1'b1;
      end else if (w_adv) begin
        r_sub        <= r_sub + 1'b1;
        r_tick       <= 1'b1;
        r_row_strobe <= (r_sub == SUB_MAX);
        if (r_sub == SUB_MAX) begin
          r_row <= r_row + 1'b1;
          if (r_row == ROW_MAX) begin
            r_bar <= r_bar + 1'b1;
          end
        end
      end
    end
  end

  assign o_tick       = r_tick;
  assign o_row_strobe = r_row_strobe;
  assign o_subtick    = r_sub;
  assign o_row        = r_row;
  assign o_bar        = r_bar;
  assign o_playing    = (r_state == ST_PLAYING);
  assign o_song_end   = r_song_end;

endmodule
